uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver that replaces the fixed 8N1 receive path inside the UART top level.
- Configurable clock rate, baud, data width and oversampling.
- Majority-vote sampling, false-start rejection, and framing, parity and overrun detection.
- Delivers each received word through a valid/ready holding register, so the downstream RAM-write logic can stall without corrupting the byte being received.

Parameters:
CLK_HZ, 25000000, system clock frequency in Hz.
BAUD, 115200, line rate in bits/s.
DATA_BITS, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, sample ticks per bit; legal values 8 or 16.
PARITY_ODD, 0, parity sense when UART_PARITY_EN is defined: 0 = even, 1 = odd.

Ports:
ext_clk_25m  input  1  system clock; all logic on the rising edge.
ext_rst  input  1  synchronous, active-high reset.
uart_rx  input  1  asynchronous serial line; idles high.
rx_data  output  DATA_BITS  received word, LSB first on the line.
rx_valid  output  1  rx_data and the flags are valid.
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready.
frame_err  output  1  stop bit sampled low for the held word.
parity_err  output  1  parity mismatch for the held word; always 0 without UART_PARITY_EN.
overrun  output  1  one-cycle pulse: a completed word was dropped.
busy  output  1  high in any state other than IDLE.

Behaviour:
Reset and synchronisation
- Reset values: rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0, FSM = IDLE, all counters = 0.
- uart_rx passes through a 2-flop synchroniser; both flops reset to 1. Only the synchronised signal is used downstream.
- Reset asserted mid-frame aborts the frame. The partial word is discarded and no rx_valid is produced.

Timing
- Tick generator: DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), minimum 1.
- A counter 0..DIV-1 produces a one-cycle tick at DIV-1. It runs only while busy and restarts at 0 on IDLE→START.
- Bit phase counter runs 0..OVERSAMPLE-1 per bit.
- Bit value = majority of the samples taken at phases M-1, M and M+1, where M = OVERSAMPLE/2. The value is evaluated on the tick at phase M+1.

FSM states and transitions
- IDLE: enter START on a synchronised 1→0 transition.
- START: majority = 1 → false start, return to IDLE with no output. Majority = 0 → continue to phase OVERSAMPLE-1, then go to DATA.
- DATA: shift in DATA_BITS bits, LSB first. Then go to PARITY if UART_PARITY_EN is defined, otherwise STOP.
- PARITY: sample one bit and compare against the parity of the data bits; then go to STOP.
- STOP: evaluate the stop bit at phase M+1. Commit the word (see below) and go to IDLE immediately; do not wait for the remaining half bit, so back-to-back frames are tolerated.
- STOP with stop = 0: set frame_err for that word and go to BREAK_WAIT instead of IDLE.
- BREAK_WAIT: remain until the synchronised line has been high for one full bit time, then go to IDLE.

Commit and handshake
- Commit happens in the cycle after the stop evaluation tick.
- If the holding register is empty, or is being consumed in that same cycle (rx_valid && rx_ready): load rx_data, frame_err and parity_err, and set rx_valid = 1.
- Otherwise: keep the old word and flags unchanged, drop the new word, and pulse overrun = 1 for one cycle.
- rx_valid clears in the cycle after rx_valid && rx_ready, unless a new word commits in that same cycle.
- rx_data and the flags stay stable while rx_valid = 1 and rx_ready = 0.
- Latency from the stop-bit mid-sample tick to rx_valid high: 1 clock.

Optional Feature:
Macro UART_PARITY_EN.
- Defined: one parity bit follows the data bits; the PARITY state is included. parity_err = 1 when XOR(data, parity bit) does not equal PARITY_ODD.
- Not defined: no PARITY state; the frame is start + DATA_BITS + stop, and parity_err is tied to 0.

Test Plan:
Parameters for all scenarios: CLK_HZ = 25000000, BAUD = 1562500, OVERSAMPLE = 16, so DIV = 1 and one bit = 16 clocks.
- 8N1 byte 0x55 (macro off) → rx_valid rises 1 clock after the stop mid-sample; rx_data = 0x55; frame_err = 0; parity_err = 0.
- Line low for 6 clocks, then high (glitch) → returns to IDLE with busy low; rx_valid never asserted.
- Frame 0xA3 with stop bit = 0, then line high for 16 clocks → rx_data = 0xA3, frame_err = 1; FSM passes through BREAK_WAIT to IDLE.
- Two frames 0x11 then 0x22, rx_ready held at 0 → rx_data stays 0x11; overrun pulses once, 1 clock after the second stop mid-sample.
- Same two frames with rx_ready = 1 in the commit cycle → 0x22 loads with no overrun pulse.
- UART_PARITY_EN defined, PARITY_ODD = 0, data 0x07 with parity bit 0 → parity_err = 1; with parity bit 1 → parity_err = 0.
- Reset pulsed during the 4th data bit, then a frame 0x3C → no output from the aborted frame; 0x3C received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority-vote sampling and a valid/ready
// holding register. Define UART_PARITY_EN to add one parity bit after the data bits.
module uart_rx_param #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 ext_clk_25m,
  input  logic                 ext_rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PH_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS + 1);
  localparam int M       = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_LO    = PH_W'(M - 1);
  localparam logic [PH_W-1:0]  PH_MID   = PH_W'(M);
  localparam logic [PH_W-1:0]  PH_EVAL  = PH_W'(M + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
`ifdef UART_PARITY_EN
    , ST_PARITY = 3'd5
`endif
  } state_t;

  state_t state_r;
  state_t state_nx_s;

  logic                 sync1_r;
  logic                 sync2_r;
  logic                 prev_r;
  logic                 line_s;
  logic                 start_s;
  logic                 tick_s;
  logic                 eval_s;
  logic                 bit_end_s;
  logic                 maj_s;
  logic [DIV_W-1:0]     div_cnt_r;
  logic [PH_W-1:0]      phase_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [1:0]           samp_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 shift_en_s;
  logic                 commit_s;
  logic                 break_entry_s;
`ifdef UART_PARITY_EN
  logic                 par_en_s;
  logic                 par_bit_r;
`endif

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef UART_PARITY_EN
  function automatic logic parity_fail(input logic [DATA_BITS-1:0] data, input logic par_bit);
    return (^{data, par_bit}) != PARITY_ODD[0];
  endfunction
`endif

  // Line synchroniser, plus a history flop for falling-edge detection.
  always_ff @(posedge ext_clk_25m) begin
    if (ext_rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= uart_rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign line_s    = sync2_r;
  assign start_s   = prev_r & ~line_s;
  assign tick_s    = (state_r != ST_IDLE) && (div_cnt_r == DIV_LAST);
  assign eval_s    = tick_s && (phase_r == PH_EVAL);
  assign bit_end_s = tick_s && (phase_r == PH_LAST);
  // The third vote is the live sample taken on the evaluation tick itself.
  assign maj_s     = majority3(samp_r[0], samp_r[1], line_s);

  // FSM state register; busy is registered from the next state so it tracks state exactly.
  always_ff @(posedge ext_clk_25m) begin
    if (ext_rst) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s != ST_IDLE);
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nx_s = ST_START;
        else         state_nx_s = ST_IDLE;
      end
      ST_START: begin
        if (eval_s && maj_s) state_nx_s = ST_IDLE;
        else if (bit_end_s)  state_nx_s = ST_DATA;
        else                 state_nx_s = ST_START;
      end
      ST_DATA: begin
        if (bit_end_s && (bit_cnt_r == BIT_LAST)) begin
`ifdef UART_PARITY_EN
          state_nx_s = ST_PARITY;
`else
          state_nx_s = ST_STOP;
`endif
        end else begin
          state_nx_s = ST_DATA;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) state_nx_s = ST_STOP;
        else           state_nx_s = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (eval_s) begin
          if (maj_s) state_nx_s = ST_IDLE;
          else       state_nx_s = ST_BREAK;
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (tick_s && line_s && (phase_r == PH_LAST)) state_nx_s = ST_IDLE;
        else                                          state_nx_s = ST_BREAK;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM output strobes for the datapath.
  always_comb begin
    shift_en_s    = 1'b0;
    commit_s      = 1'b0;
    break_entry_s = 1'b0;
`ifdef UART_PARITY_EN
    par_en_s      = 1'b0;
`endif
    case (state_r)
      ST_DATA: shift_en_s = eval_s;
`ifdef UART_PARITY_EN
      ST_PARITY: par_en_s = eval_s;
`endif
      ST_STOP: begin
        commit_s      = eval_s;
        break_entry_s = eval_s & ~maj_s;
      end
      default: begin
        shift_en_s    = 1'b0;
        commit_s      = 1'b0;
        break_entry_s = 1'b0;
      end
    endcase
  end

  // Tick divider, bit phase, data-bit count and the two stored votes.
  always_ff @(posedge ext_clk_25m) begin
    if (ext_rst) begin
      div_cnt_r <= '0;
      phase_r   <= '0;
      bit_cnt_r <= '0;
      samp_r    <= '0;
    end else begin
      if ((state_r == ST_IDLE) || tick_s) div_cnt_r <= '0;
      else                                div_cnt_r <= div_cnt_r + 1'b1;

      // In BREAK the phase counts consecutive high ticks and restarts on any low sample.
      if ((state_r == ST_IDLE) || break_entry_s) begin
        phase_r <= '0;
      end else if (tick_s) begin
        if ((state_r == ST_BREAK) && !line_s) phase_r <= '0;
        else if (phase_r == PH_LAST)          phase_r <= '0;
        else                                  phase_r <= phase_r + 1'b1;
      end

      if (state_r != ST_DATA) bit_cnt_r <= '0;
      else if (bit_end_s)     bit_cnt_r <= bit_cnt_r + 1'b1;

      if (tick_s && (phase_r == PH_LO))  samp_r[0] <= line_s;
      if (tick_s && (phase_r == PH_MID)) samp_r[1] <= line_s;
    end
  end

  // Frame capture: data shifts in LSB first, parity bit kept separately.
  always_ff @(posedge ext_clk_25m) begin
    if (ext_rst) begin
      shift_r   <= '0;
`ifdef UART_PARITY_EN
      par_bit_r <= 1'b0;
`endif
    end else begin
      if (shift_en_s) shift_r <= {maj_s, shift_r[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
      if (par_en_s) par_bit_r <= maj_s;
`endif
    end
  end

  // Holding register: a commit loads only when the slot is empty or draining this cycle.
  always_ff @(posedge ext_clk_25m) begin
    if (ext_rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit_s) begin
      if (!rx_valid || rx_ready) begin
        rx_data   <= shift_r;
        rx_valid  <= 1'b1;
        frame_err <= ~maj_s;
`ifdef UART_PARITY_EN
        parity_err <= parity_fail(shift_r, par_bit_r);
`else
        parity_err <= 1'b0;
`endif
        overrun   <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frames checked against a frame-level model
// of expected words, flags, and event timing for uart_rx_param.
module tb_uart_rx_param;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = 16;
  localparam int PARITY_ODD = 0;
`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int STOP_IDX = 1 + DATA_BITS + PAR_BITS;
  // 1 edge into the first flop, 1 more synchroniser flop, 1 edge-detect edge, phases 0..M+1, then the commit edge.
  localparam int VALID_LAT = 3 + (OVERSAMPLE / 2 + 1) + 1 + STOP_IDX * BIT_CLKS;

  logic                 ext_clk_25m = 1'b0;
  logic                 ext_rst;
  logic                 uart_rx;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int frame_start = 0;
  int rise_cyc = 0, rise_count = 0;
  int ovr_cyc = 0, ovr_count = 0;
  logic valid_prev = 1'b0, ready_prev = 1'b0;
  logic [31:0] held_word = '0;
  logic [31:0] exp_q[$];

  uart_rx_param #(
    .CLK_HZ(25000000), .BAUD(1562500), .DATA_BITS(DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE), .PARITY_ODD(PARITY_ODD)
  ) dut (
    .ext_clk_25m(ext_clk_25m), .ext_rst(ext_rst), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  always #5 ext_clk_25m = ~ext_clk_25m;
  always @(posedge ext_clk_25m) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected delivered word: {frame_err, parity_err, data}.
  function automatic logic [31:0] model_word(input logic [DATA_BITS-1:0] d, input logic p, input logic s);
    logic perr;
    perr = 1'b0;
    if (PAR_BITS == 1) perr = ((^d) ^ p) != PARITY_ODD[0];
    return 32'({~s, perr, d});
  endfunction

  task automatic tick();
    @(posedge ext_clk_25m);
    #2;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (BIT_CLKS) tick();
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic p, input logic s);
    logic [DATA_BITS+2:0] fr;
    fr = {s, p, d, 1'b0};
    frame_start = cyc;
    for (int i = 0; i < DATA_BITS + 1 + PAR_BITS; i++) drive_bit(fr[i]);
    drive_bit(s);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  // Output monitor: events, hold stability while stalled, and scoreboard on each acceptance.
  initial begin
    forever begin
      @(negedge ext_clk_25m);
      if (overrun) begin
        ovr_count++;
        ovr_cyc = cyc;
      end
      if (rx_valid && !valid_prev) begin
        rise_count++;
        rise_cyc = cyc;
      end
      if (rx_valid && valid_prev && !ready_prev)
        check_eq("hold_stable", 32'({frame_err, parity_err, rx_data}), held_word);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check_eq("word_expected", 32'(exp_q.size()), 32'd1);
        else check_eq("word", 32'({frame_err, parity_err, rx_data}), exp_q.pop_front());
      end
      valid_prev = rx_valid;
      ready_prev = rx_ready;
      held_word  = 32'({frame_err, parity_err, rx_data});
    end
  end

  initial begin
    int r0, o0, c2;
    logic [DATA_BITS-1:0] d;
    logic p, s;
    uart_rx = 1'b1; rx_ready = 1'b0; ext_rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
    check_eq("rst_data", 32'(rx_data), 32'd0);
    ext_rst = 1'b0;
    repeat (4) tick();

    // Plain frame, held to inspect latency and contents.
    r0 = rise_count;
    exp_q.push_back(model_word(8'h55, ^8'h55, 1'b1));
    send_frame(8'h55, ^8'h55, 1'b1);
    check_eq("lat_valid", 32'(rise_cyc - frame_start), 32'(VALID_LAT));
    check_eq("rise_once", 32'(rise_count - r0), 32'd1);
    check_eq("data_55", 32'(rx_data), 32'h55);
    check_eq("flags_55", 32'({frame_err, parity_err}), 32'd0);
    check_eq("idle_after_stop", 32'(busy), 32'd0);
    rx_ready = 1'b1;
    repeat (2) tick();
    check_eq("valid_clear", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;

    // Short glitch must be rejected as a false start.
    r0 = rise_count;
    uart_rx = 1'b0;
    repeat (6) tick();
    check_eq("glitch_busy", 32'(busy), 32'd1);
    uart_rx = 1'b1;
    repeat (20) tick();
    check_eq("glitch_idle", 32'(busy), 32'd0);
    check_eq("glitch_no_word", 32'(rise_count - r0), 32'd0);

    // Stop bit low: word flagged, then wait for a full bit of idle line.
    exp_q.push_back(model_word(8'hA3, ^8'hA3, 1'b0));
    send_frame(8'hA3, ^8'hA3, 1'b0);
    check_eq("break_busy", 32'(busy), 32'd1);
    check_eq("break_data", 32'(rx_data), 32'hA3);
    check_eq("break_ferr", 32'(frame_err), 32'd1);
    uart_rx = 1'b1;
    repeat (16) tick();
    check_eq("break_wait", 32'(busy), 32'd1);
    repeat (4) tick();
    check_eq("break_done", 32'(busy), 32'd0);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    repeat (4) tick();

    // Two frames, consumer stalled: second word dropped with one overrun pulse.
    o0 = ovr_count;
    exp_q.push_back(model_word(8'h11, ^8'h11, 1'b1));
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    check_eq("ovr_count", 32'(ovr_count - o0), 32'd1);
    check_eq("ovr_lat", 32'(ovr_cyc - frame_start), 32'(VALID_LAT));
    check_eq("ovr_keep", 32'(rx_data), 32'h11);
    rx_ready = 1'b1; repeat (2) tick(); rx_ready = 1'b0;
    repeat (4) tick();

    // Same two frames, consumer accepts in the commit cycle of the second.
    o0 = ovr_count;
    exp_q.push_back(model_word(8'h11, ^8'h11, 1'b1));
    exp_q.push_back(model_word(8'h22, ^8'h22, 1'b1));
    c2 = cyc + STOP_IDX * BIT_CLKS + BIT_CLKS;
    fork
      begin
        send_frame(8'h11, ^8'h11, 1'b1);
        send_frame(8'h22, ^8'h22, 1'b1);
      end
      begin
        wait_cyc(c2 + VALID_LAT - 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    check_eq("swap_no_ovr", 32'(ovr_count - o0), 32'd0);
    check_eq("swap_data", 32'(rx_data), 32'h22);
    check_eq("swap_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1; repeat (2) tick();

    // Parity sense (flag stays 0 when parity is not built in).
    exp_q.push_back(model_word(8'h07, 1'b0, 1'b1));
    send_frame(8'h07, 1'b0, 1'b1);
    exp_q.push_back(model_word(8'h07, 1'b1, 1'b1));
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) tick();

    // Reset during the 4th data bit, then a clean frame.
    r0 = rise_count;
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    uart_rx = 1'b0;
    repeat (8) tick();
    ext_rst = 1'b1; uart_rx = 1'b1;
    repeat (2) tick();
    ext_rst = 1'b0;
    tick();
    check_eq("abort_busy", 32'(busy), 32'd0);
    repeat (40) tick();
    check_eq("abort_no_word", 32'(rise_count - r0), 32'd0);
    exp_q.push_back(model_word(8'h3C, ^8'h3C, 1'b1));
    send_frame(8'h3C, ^8'h3C, 1'b1);
    repeat (4) tick();
    check_eq("after_abort_q", 32'(exp_q.size()), 32'd0);

    // Randomized frames with random gaps, occasional bad stop bits and parity bits.
    for (int n = 0; n < 30; n++) begin
      d = DATA_BITS'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 7) != 0);
      exp_q.push_back(model_word(d, p, s));
      send_frame(d, p, s);
      uart_rx = 1'b1;
      if (!s) repeat (20 + $urandom_range(0, 5)) tick();
      else    repeat ($urandom_range(0, 5)) tick();
    end
    repeat (10) tick();
    check_eq("final_q", 32'(exp_q.size()), 32'd0);
    check_eq("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
